// File: rtl/control_enemigos_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_enemigos_if
//  Description : Signal bundle between the enemy-traffic controller and its
//                surroundings (frame timing, game run flag, renderer pixel
//                feedback, player sprite flag, slot outputs, status pulses).
//                Signal suffixes are written from the controller's viewpoint.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_enemigos_if;
    // Frame timing / game control
    logic       frame_tick_i;
    logic       run_i;
    // Enemy renderer feedback and player sprite flag
    logic [1:0] ene_data_i;
    logic [7:0] ene_rgb0_i;
    logic [7:0] ene_rgb1_i;
    logic       player_data_i;
    // Slot outputs to the enemy renderers
    logic [1:0] enable_o;
    logic [9:0] posx0_o;
    logic [9:0] posy0_o;
    logic [9:0] posx1_o;
    logic [9:0] posy1_o;
    // Merged pixel and status
    logic       pix_valid_o;
    logic [7:0] pix_rgb_o;
    logic       collision_o;
    logic       passed_o;
    logic [1:0] state_o;

    // Game-side driver: produces the controller inputs, observes its outputs
    modport master (
        output frame_tick_i, run_i, ene_data_i, ene_rgb0_i, ene_rgb1_i,
               player_data_i,
        input  enable_o, posx0_o, posy0_o, posx1_o, posy1_o,
               pix_valid_o, pix_rgb_o, collision_o, passed_o, state_o
    );

    // Controller side
    modport slave (
        input  frame_tick_i, run_i, ene_data_i, ene_rgb0_i, ene_rgb1_i,
               player_data_i,
        output enable_o, posx0_o, posy0_o, posx1_o, posy1_o,
               pix_valid_o, pix_rgb_o, collision_o, passed_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/control_enemigos.sv
`default_nettype none
// ============================================================================
//  Module      : control_enemigos
//  Description : Enemy-traffic controller. Owns two enemy sprite slots,
//                spawns enemies into pseudo-random lanes once per spawn gap,
//                scrolls them down each frame, retires them at the bottom,
//                merges the renderer pixels and detects player collisions.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_enemigos #(
    parameter int LANE_BASE    = 200,
    parameter int LANE_PITCH   = 60,
    parameter int SPEED        = 4,
    parameter int SCREEN_Y     = 480,
    parameter int SPAWN_GAP    = 90,
    parameter int CRASH_FRAMES = 60
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    control_enemigos_if.slave  bus_if
);

    // Widths of the frame counters
    localparam int GAP_W   = $clog2(SPAWN_GAP);
    localparam int CRASH_W = $clog2(CRASH_FRAMES);

    // Last value of each counter before it triggers
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(SPAWN_GAP - 1);
    localparam logic [CRASH_W-1:0] CRASH_LAST = CRASH_W'(CRASH_FRAMES - 1);

    // A new enemy may not share a lane with an enemy still this close to the top
    localparam logic [9:0] SPAWN_CLEAR = 10'd60;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;
    localparam logic [9:0] LANE_X0     = 10'(LANE_BASE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CRASH = 2'd2
    } state_e;

    // x position of a lane
    function automatic logic [9:0] lane_x(input logic [1:0] lane);
        return 10'(LANE_BASE + int'(lane) * LANE_PITCH);
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e                 state_q;
    logic [1:0]             enable_q;
    logic [1:0][9:0]        posx_q;
    logic [1:0][9:0]        posy_q;
    logic [1:0][1:0]        lane_q;
    logic [7:0]             lfsr_q;
    logic [GAP_W-1:0]       gap_q;
    logic [CRASH_W-1:0]     crash_q;
    logic                   pix_valid_q;
    logic [7:0]             pix_rgb_q;
    logic                   collision_q;
    logic                   passed_q;

    // ------------------------------------------------------------------
    // Frame-tick results (what PLAY commits on a tick)
    // ------------------------------------------------------------------
    logic [1:0]             move_en;
    logic [1:0][9:0]        move_y;
    logic                   lane_clash;
    logic [1:0]             spawn_lane;
    logic                   slot_free;
    logic                   spawn_idx;
    logic                   spawn;
    logic [1:0]             enable_d;
    logic [1:0][9:0]        posx_d;
    logic [1:0][9:0]        posy_d;
    logic [1:0][1:0]        lane_d;
    logic [7:0]             lfsr_d;
    logic [GAP_W-1:0]       gap_d;
    logic                   passed_d;

    // Pixel qualification: renderers keep stale data while disabled
    logic [1:0]             qual;
    logic                   hit;

    assign qual = bus_if.ene_data_i & enable_q;
    assign hit  = bus_if.player_data_i & (|qual);

    // Move/retire active slots, then decide on a spawn into the lowest free slot
    always_comb begin
        move_en    = enable_q;
        move_y     = posy_q;
        passed_d   = 1'b0;
        lane_clash = 1'b0;

        for (int i = 0; i < 2; i++) begin
            if (enable_q[i]) begin
                // 11-bit compare so the sum cannot wrap past the threshold
                if (({1'b0, posy_q[i]} + 11'(SPEED)) >= 11'(SCREEN_Y)) begin
                    move_en[i] = 1'b0;
                    passed_d   = 1'b1;
                end else begin
                    move_y[i] = posy_q[i] + 10'(SPEED);
                end
            end
        end

        // Lane choice sees the positions after this tick's move
        for (int i = 0; i < 2; i++) begin
            if (move_en[i] && (lane_q[i] == lfsr_q[1:0]) && (move_y[i] < SPAWN_CLEAR)) begin
                lane_clash = 1'b1;
            end
        end

        // Single retry: next lane with natural modulo-4 wrap
        spawn_lane = lane_clash ? (lfsr_q[1:0] + 2'd1) : lfsr_q[1:0];
        slot_free  = ~(&move_en);
        spawn_idx  = move_en[0];
        spawn      = (gap_q == GAP_LAST) && slot_free;

        enable_d = move_en;
        posx_d   = posx_q;
        posy_d   = move_y;
        lane_d   = lane_q;
        if (spawn) begin
            enable_d[spawn_idx] = 1'b1;
            posx_d[spawn_idx]   = lane_x(spawn_lane);
            posy_d[spawn_idx]   = 10'd0;
            lane_d[spawn_idx]   = spawn_lane;
        end

        // Counter holds at its last value while both slots are busy
        if (gap_q != GAP_LAST) begin
            gap_d = gap_q + GAP_W'(1);
        end else if (spawn) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q;
        end

        lfsr_d = spawn ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                       : lfsr_q;
    end

    // Game FSM with slot registers, pulses and the registered pixel merge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            enable_q    <= '0;
            posx_q      <= {2{LANE_X0}};
            posy_q      <= '0;
            lane_q      <= '0;
            lfsr_q      <= LFSR_SEED;
            gap_q       <= '0;
            crash_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_rgb_q   <= 8'd0;
            collision_q <= 1'b0;
            passed_q    <= 1'b0;
        end else begin
            collision_q <= 1'b0;
            passed_q    <= 1'b0;

            // Merge runs in every state
            pix_valid_q <= |qual;
            pix_rgb_q   <= qual[0] ? bus_if.ene_rgb0_i :
                           qual[1] ? bus_if.ene_rgb1_i : 8'd0;

            case (state_q)
                ST_IDLE: begin
                    if (bus_if.run_i) begin
                        state_q <= ST_PLAY;
                        gap_q   <= '0;
                    end
                end

                ST_PLAY: begin
                    // A collision beats both run dropping and a frame tick
                    if (hit) begin
                        collision_q <= 1'b1;
                        crash_q     <= '0;
                        state_q     <= ST_CRASH;
                    end else if (!bus_if.run_i) begin
                        state_q  <= ST_IDLE;
                        enable_q <= '0;
                        posx_q   <= {2{LANE_X0}};
                        posy_q   <= '0;
                        lane_q   <= '0;
                    end else if (bus_if.frame_tick_i) begin
                        enable_q <= enable_d;
                        posx_q   <= posx_d;
                        posy_q   <= posy_d;
                        lane_q   <= lane_d;
                        lfsr_q   <= lfsr_d;
                        gap_q    <= gap_d;
                        passed_q <= passed_d;
                    end
                end

                ST_CRASH: begin
                    // Slots frozen; ticks only count down the crash
                    if (bus_if.frame_tick_i) begin
                        if (crash_q == CRASH_LAST) begin
                            state_q  <= bus_if.run_i ? ST_PLAY : ST_IDLE;
                            crash_q  <= '0;
                            gap_q    <= '0;
                            enable_q <= '0;
                            posx_q   <= {2{LANE_X0}};
                            posy_q   <= '0;
                            lane_q   <= '0;
                        end else begin
                            crash_q <= crash_q + CRASH_W'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus_if.enable_o    = enable_q;
    assign bus_if.posx0_o     = posx_q[0];
    assign bus_if.posy0_o     = posy_q[0];
    assign bus_if.posx1_o     = posx_q[1];
    assign bus_if.posy1_o     = posy_q[1];
    assign bus_if.pix_valid_o = pix_valid_q;
    assign bus_if.pix_rgb_o   = pix_rgb_q;
    assign bus_if.collision_o = collision_q;
    assign bus_if.passed_o    = passed_q;
    assign bus_if.state_o     = state_q;

endmodule
`default_nettype wire
